// File: rtl/clkrst_seq.sv
// clkrst_seq: free-running timebase (fast strobe, slow tick, heartbeat)
// plus a staged power-up sequencer with per-stage delays counted in slow
// ticks. A restart powers the stages down highest-first, then re-runs the
// power-up sequence without needing a global reset.
module clkrst_seq #(
    parameter int unsigned                FAST_DIV  = 250,
    parameter int unsigned                SLOW_DIV  = 200000,
    parameter int unsigned                N_STAGES  = 2,
    parameter int unsigned                DLY_W     = 4,
    parameter logic [N_STAGES*DLY_W-1:0]  STAGE_DLY = {4'd2, 4'd2}
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                restart,
    output logic                strobe_fast,
    output logic                tick_slow,
    output logic                heartbeat,
    output logic [N_STAGES-1:0] stage_en,
    output logic                seq_done
);

    localparam int unsigned FW = (FAST_DIV > 2) ? $clog2(FAST_DIV) : 1;
    localparam int unsigned SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam int unsigned KW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [FW-1:0]    FAST_MAX = FW'(FAST_DIV - 1);
    localparam logic [SW-1:0]    SLOW_MAX = SW'(SLOW_DIV - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(N_STAGES - 1);
    localparam logic [DLY_W:0]   DCNT_ONE = 1;
    localparam logic [DLY_W-1:0] DLY_MIN  = 1;

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DONE = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    logic [FW-1:0]       fcnt;
    logic [SW-1:0]       scnt;

    state_t              state, state_nxt;
    logic [KW-1:0]       k, k_nxt;
    logic [DLY_W-1:0]    dcnt, dcnt_nxt;
    logic [N_STAGES-1:0] stage_nxt;

    logic [DLY_W-1:0]    cur_dly;
    logic [DLY_W:0]      dcnt_inc;
    logic [KW-1:0]       top_idx;

    // Fast divider: wraps every FAST_DIV cycles, strobe registered on the wrap value.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            fcnt        <= '0;
            strobe_fast <= 1'b0;
        end else begin
            strobe_fast <= (fcnt == FAST_MAX);
            if (fcnt == FAST_MAX) begin
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Slow divider: counts fast strobes, emits tick and toggles heartbeat on wrap.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            scnt      <= '0;
            tick_slow <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            tick_slow <= strobe_fast && (scnt == SLOW_MAX);
            if (strobe_fast) begin
                if (scnt == SLOW_MAX) begin
                    scnt      <= '0;
                    heartbeat <= ~heartbeat;
                end else begin
                    scnt <= scnt + SW'(1);
                end
            end
        end
    end

    // Effective delay of the stage currently being powered up (0 counts as 1).
    always_comb begin
        cur_dly = '0;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            if (k == KW'(i)) begin
                cur_dly = STAGE_DLY[i*DLY_W +: DLY_W];
            end
        end
        if (cur_dly == '0) begin
            cur_dly = DLY_MIN;
        end
    end

    assign dcnt_inc = {1'b0, dcnt} + DCNT_ONE;

    // Index of the highest enabled stage, the next one to drop during power-down.
    always_comb begin
        top_idx = '0;
        for (int unsigned i = 0; i < N_STAGES; i++) begin
            if (stage_en[i]) begin
                top_idx = KW'(i);
            end
        end
    end

    // Sequencer state and stage-enable registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= ST_UP;
            k        <= '0;
            dcnt     <= '0;
            stage_en <= '0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            dcnt     <= dcnt_nxt;
            stage_en <= stage_nxt;
        end
    end

    // Next-state logic: restart beats a coincident tick in UP/DONE, is ignored in DOWN.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dcnt_nxt  = dcnt;
        stage_nxt = stage_en;
        case (state)
            ST_UP: begin
                if (restart) begin
                    state_nxt = ST_DOWN;
                    dcnt_nxt  = '0;
                end else if (tick_slow) begin
                    if (dcnt_inc == {1'b0, cur_dly}) begin
                        for (int unsigned i = 0; i < N_STAGES; i++) begin
                            if (k == KW'(i)) begin
                                stage_nxt[i] = 1'b1;
                            end
                        end
                        dcnt_nxt = '0;
                        if (k == K_LAST) begin
                            state_nxt = ST_DONE;
                        end else begin
                            k_nxt = k + KW'(1);
                        end
                    end else begin
                        dcnt_nxt = dcnt_inc[DLY_W-1:0];
                    end
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_nxt = ST_DOWN;
                    dcnt_nxt  = '0;
                end
            end
            ST_DOWN: begin
                if (stage_en == '0) begin
                    state_nxt = ST_UP;
                    k_nxt     = '0;
                    dcnt_nxt  = '0;
                end else if (tick_slow) begin
                    for (int unsigned i = 0; i < N_STAGES; i++) begin
                        if (top_idx == KW'(i)) begin
                            stage_nxt[i] = 1'b0;
                        end
                    end
                    if (top_idx == '0) begin
                        state_nxt = ST_UP;
                        k_nxt     = '0;
                        dcnt_nxt  = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_UP;
                k_nxt     = '0;
                dcnt_nxt  = '0;
            end
        endcase
    end

    assign seq_done = &stage_en;

endmodule

// File: tb/tb_clkrst_seq.sv
// Bench for clkrst_seq: hand-derived checkpoint table for the bring-up,
// restart and power-down scenarios, an async reset mid-sequence, then
// randomized restarts/resets against a cycle-count based reference model.
module tb_clkrst_seq;

    localparam int F = 4;
    localparam int S = 3;
    localparam int N = 3;
    localparam int DW = 4;
    localparam int P = F * S;
    localparam logic [N*DW-1:0] DLY = {4'd0, 4'd3, 4'd2};

    logic         clk = 1'b0;
    logic         areset_n = 1'b1;
    logic         restart = 1'b0;
    logic         strobe_fast;
    logic         tick_slow;
    logic         heartbeat;
    logic [N-1:0] stage_en;
    logic         seq_done;

    clkrst_seq #(
        .FAST_DIV (F),
        .SLOW_DIV (S),
        .N_STAGES (N),
        .DLY_W    (DW),
        .STAGE_DLY(DLY)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .restart    (restart),
        .strobe_fast(strobe_fast),
        .tick_slow  (tick_slow),
        .heartbeat  (heartbeat),
        .stage_en   (stage_en),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: e = index of last edge since reset release (-1 = none),
    // lvl = number of stages on, ups = ticks counted since entering power-up.
    int e    = -1;
    int lvl  = 0;
    bit down = 1'b0;
    int ups  = 0;
    int cum [N];

    typedef struct {
        int         at_edge;
        int         rst_cyc;
        logic [2:0] stage;
        logic       done;
        logic       hb;
    } vec_t;

    vec_t tbl [$];

    function automatic logic exp_strobe(input int ed);
        return (ed >= 0) && (ed % F == F - 1);
    endfunction

    function automatic logic exp_tick(input int ed);
        return (ed > 0) && (ed % P == 0);
    endfunction

    function automatic logic exp_hb(input int ed);
        return (ed >= 0) && (((ed / P) % 2) == 1);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    task automatic model_edge();
        bit tk;
        tk = exp_tick(e);
        e++;
        if (!down) begin
            if (restart) begin
                down = 1'b1;
            end else if (tk && lvl < N) begin
                ups++;
                lvl = 0;
                for (int j = 0; j < N; j++) begin
                    if (cum[j] <= ups) lvl = j + 1;
                end
            end
        end else begin
            if (lvl == 0) begin
                down = 1'b0;
                ups  = 0;
            end else if (tk) begin
                lvl--;
                if (lvl == 0) begin
                    down = 1'b0;
                    ups  = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [2:0] exp_st;
        exp_st = 3'((1 << lvl) - 1);
        check("strobe_fast", 8'(strobe_fast), 8'(exp_strobe(e)));
        check("tick_slow",   8'(tick_slow),   8'(exp_tick(e)));
        check("heartbeat",   8'(heartbeat),   8'(exp_hb(e)));
        check("stage_en",    8'(stage_en),    8'(exp_st));
        check("seq_done",    8'(seq_done),    8'(lvl == N));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Called #1 after an edge: drop reset mid-cycle, hold for some edges, release mid-cycle.
    task automatic do_reset(input int cycles);
        #2;
        areset_n = 1'b0;
        restart  = 1'b0;
        e    = -1;
        lvl  = 0;
        down = 1'b0;
        ups  = 0;
        #1;
        check("async_rst_stage", 8'(stage_en), 8'h00);
        check("async_rst_hb",    8'(heartbeat), 8'h00);
        check_outputs();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        #2;
        areset_n = 1'b1;
    endtask

    initial begin
        int acc;
        acc = 0;
        for (int j = 0; j < N; j++) begin
            int d;
            d = int'(DLY[j*DW +: DW]);
            acc += (d == 0) ? 1 : d;
            cum[j] = acc;
        end

        //          edge rst  stage   done  hb
        tbl.push_back('{ 24, 0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{ 25, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{ 60, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{ 61, 0, 3'b011, 1'b0, 1'b1});
        tbl.push_back('{ 72, 0, 3'b011, 1'b0, 1'b0});
        tbl.push_back('{ 73, 0, 3'b111, 1'b1, 1'b0});
        tbl.push_back('{ 80, 1, 3'b111, 1'b1, 1'b0});
        tbl.push_back('{ 84, 0, 3'b111, 1'b1, 1'b1});
        tbl.push_back('{ 85, 0, 3'b011, 1'b0, 1'b1});
        tbl.push_back('{ 97, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{108, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{109, 0, 3'b000, 1'b0, 1'b1});
        tbl.push_back('{132, 0, 3'b000, 1'b0, 1'b1});
        tbl.push_back('{133, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{168, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{169, 0, 3'b011, 1'b0, 1'b0});
        tbl.push_back('{181, 0, 3'b111, 1'b1, 1'b1});
        tbl.push_back('{190, 1, 3'b111, 1'b1, 1'b1});
        tbl.push_back('{191, 20, 3'b111, 1'b1, 1'b1});
        tbl.push_back('{211, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{216, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{217, 0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{240, 0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{241, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{276, 1, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{277, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{288, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{289, 0, 3'b000, 1'b0, 1'b0});
        tbl.push_back('{313, 0, 3'b001, 1'b0, 1'b0});
        tbl.push_back('{348, 0, 3'b001, 1'b0, 1'b1});
        tbl.push_back('{349, 0, 3'b011, 1'b0, 1'b1});

        // Power-on reset.
        #2;
        areset_n = 1'b0;
        #1;
        check("por_stage",  8'(stage_en),    8'h00);
        check("por_done",   8'(seq_done),    8'h00);
        check("por_strobe", 8'(strobe_fast), 8'h00);
        check("por_tick",   8'(tick_slow),   8'h00);
        check("por_hb",     8'(heartbeat),   8'h00);
        @(posedge clk);
        @(posedge clk);
        #3;
        areset_n = 1'b1;

        // Strobe phase and the checkpoint table.
        while (e < 2) step();
        check("strobe_before_first", 8'(strobe_fast), 8'h00);
        step();
        check("strobe_first", 8'(strobe_fast), 8'h01);
        foreach (tbl[i]) begin
            while (e < tbl[i].at_edge) step();
            check($sformatf("tbl%0d_stage", i), 8'(stage_en),  8'(tbl[i].stage));
            check($sformatf("tbl%0d_done", i),  8'(seq_done),  8'(tbl[i].done));
            check($sformatf("tbl%0d_hb", i),    8'(heartbeat), 8'(tbl[i].hb));
            if (tbl[i].rst_cyc > 0) begin
                restart = 1'b1;
                repeat (tbl[i].rst_cyc) step();
                restart = 1'b0;
            end
        end

        // Async reset for 3 cycles with stage_en=011, then restart from edge 0.
        do_reset(3);
        while (e < 11) step();
        check("rerun_tick_before", 8'(tick_slow), 8'h00);
        step();
        check("rerun_tick", 8'(tick_slow), 8'h01);
        check("rerun_hb",   8'(heartbeat), 8'h01);
        while (e < 24) step();
        check("rerun_stage_pre", 8'(stage_en), 8'h00);
        step();
        check("rerun_stage0", 8'(stage_en), 8'h01);

        // Randomized restarts, restart holds and occasional async resets.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset(int'($urandom_range(1, 3)));
                step();
            end else begin
                if (r < 40) restart = 1'b1;
                else if (r < 60) restart = restart;
                else restart = 1'b0;
                step();
            end
        end
        restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
